// File: rtl/pe_config_loader.sv
// pe_config_loader: assembles one tile's configuration frame from a 32-bit
// valid/ready word stream into a shadow register, then commits it atomically
// to ConfigBits/ConfigBits_N. Frames for other tiles are counted and skipped.
module pe_config_loader #(
  parameter int          NoConfigBits = 65,
  parameter logic [15:0] TILE_ID      = 16'h0,
  parameter logic [7:0]  MAGIC        = 8'hC5
) (
  input  logic                    UserCLK,
  input  logic                    reset,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [NoConfigBits-1:0] ConfigBits,
  output logic [NoConfigBits-1:0] ConfigBits_N,
  output logic                    cfg_done,
  output logic                    cfg_err
);

  localparam int NWORDS = (NoConfigBits + 31) / 32;
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam logic [WCW-1:0] LASTW = WCW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SKIP, COMMIT} state_e;

  state_e                  state_q;
  logic [WCW-1:0]          word_cnt_q;
  logic [NoConfigBits-1:0] shadow_q;
  logic [NoConfigBits-1:0] cb_q, cbn_q;
  logic                    ready_q, done_q, err_q;
  logic                    xfer;
  logic                    unused_rsvd;

  // Ready comes straight from a register, so there is no path from cfg_valid.
  assign xfer         = cfg_valid & ready_q;
  // Header reserved byte carries no meaning for this loader.
  assign unused_rsvd  = ^cfg_data[23:16];

  assign cfg_ready    = ready_q;
  assign ConfigBits   = cb_q;
  assign ConfigBits_N = cbn_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;

  // Frame FSM: header decode, shadow load / skip counting, one-cycle commit.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      shadow_q   <= '0;
      cb_q       <= '0;
      cbn_q      <= '1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (cfg_data[31:24] != MAGIC) begin
              err_q <= 1'b1;
            end else begin
              word_cnt_q <= '0;
              state_q    <= (cfg_data[15:0] == TILE_ID) ? LOAD : SKIP;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            // Only bits below NoConfigBits exist; the rest of the word is dropped.
            for (int i = 0; i < NoConfigBits; i++) begin
              if (WCW'(i / 32) == word_cnt_q) shadow_q[i] <= cfg_data[i % 32];
            end
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == LASTW) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end
          end
        end
        SKIP: begin
          if (xfer) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (word_cnt_q == LASTW) state_q <= IDLE;
          end
        end
        COMMIT: begin
          cb_q    <= shadow_q;
          cbn_q   <= ~shadow_q;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader at default parameters (65 bits, tile 0).
module tb_pe_config_loader;
  localparam int N = 65;

  logic          UserCLK = 1'b0;
  logic          reset;
  logic [31:0]   cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [N-1:0]  ConfigBits, ConfigBits_N;
  logic          cfg_done, cfg_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit inv_en = 1'b0;

  pe_config_loader dut (
    .UserCLK(UserCLK), .reset(reset), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Complement invariant and done-pulse counting, sampled mid-cycle.
  always @(negedge UserCLK) begin
    if (inv_en) begin
      chk("inv_n", {31'b0, ConfigBits_N}, {31'b0, ~ConfigBits});
      if (cfg_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge UserCLK); #1;
  endtask

  // One handshake: present the word, wait for ready (bounded), take one edge.
  task automatic xfer(input logic [31:0] w);
    int n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 10) begin tick(); n++; end
    if (n == 10) chk("ready_timeout", 96'd0, 96'd1);
    tick();
    cfg_valid = 1'b0;
    cfg_data  = 32'hDEAD_BEEF;
  endtask

  task automatic frame(input logic [31:0] h, input logic [31:0] w0,
                       input logic [31:0] w1, input logic [31:0] w2, input int gap);
    logic [31:0] ws [3];
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    xfer(h);
    for (int k = 0; k < 3; k++) begin
      repeat (gap) begin
        chk("bubble_ready", {95'b0, cfg_ready}, 96'd1);
        tick();
      end
      xfer(ws[k]);
    end
  endtask

  // After the last data word: COMMIT cycle, then new config visible with done.
  task automatic expect_commit(input string tag, input logic [N-1:0] oldv, input logic [N-1:0] newv);
    chk({tag, "_rdy0"}, {95'b0, cfg_ready}, 96'd0);
    chk({tag, "_hold"}, {31'b0, ConfigBits}, {31'b0, oldv});
    chk({tag, "_done0"}, {95'b0, cfg_done}, 96'd0);
    tick();
    chk({tag, "_cb"}, {31'b0, ConfigBits}, {31'b0, newv});
    chk({tag, "_cbn"}, {31'b0, ConfigBits_N}, {31'b0, ~newv});
    chk({tag, "_done1"}, {95'b0, cfg_done}, 96'd1);
    chk({tag, "_rdy1"}, {95'b0, cfg_ready}, 96'd1);
    tick();
    chk({tag, "_done_end"}, {95'b0, cfg_done}, 96'd0);
  endtask

  localparam logic [N-1:0] V2 = 65'h1_01234567_89ABCDEF;
  localparam logic [N-1:0] V3 = 65'h0_55555555_AAAAAAAA;
  localparam logic [N-1:0] V4 = 65'h1_80000000_00000001;

  initial begin
    int d0;
    cfg_valid = 1'b0;
    cfg_data  = 32'h0;
    reset     = 1'b1;
    tick(); tick();
    reset  = 1'b0;
    inv_en = 1'b1;

    // Reset state
    chk("rst_cb",   {31'b0, ConfigBits},   96'd0);
    chk("rst_cbn",  {31'b0, ConfigBits_N}, {31'b0, {N{1'b1}}});
    chk("rst_rdy",  {95'b0, cfg_ready},    96'd1);
    chk("rst_done", {95'b0, cfg_done},     96'd0);
    chk("rst_err",  {95'b0, cfg_err},      96'd0);

    // Basic load, word 2 keeps only bit 0
    frame(32'hC500_0000, 32'h89AB_CDEF, 32'h0123_4567, 32'hFFFF_FFFF, 0);
    expect_commit("t2", '0, V2);
    chk("t2_pulses", 96'(done_cnt), 96'd1);

    // Frame for another tile is skipped
    d0 = done_cnt;
    frame(32'hC500_0007, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0);
    tick(); tick();
    chk("t3_cb_hold", {31'b0, ConfigBits}, {31'b0, V2});
    chk("t3_nodone",  96'(done_cnt), 96'(d0));
    frame(32'hC500_0000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 0);
    expect_commit("t3", V2, V3);

    // Bad magic sets sticky error, loader stays usable
    xfer(32'h1200_0000);
    chk("t4_err",  {95'b0, cfg_err},   96'd1);
    chk("t4_rdy",  {95'b0, cfg_ready}, 96'd1);
    chk("t4_hold", {31'b0, ConfigBits}, {31'b0, V3});
    frame(32'hC500_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0003, 0);
    expect_commit("t4", V3, V4);
    chk("t4_err_sticky", {95'b0, cfg_err}, 96'd1);

    // Two-cycle bubbles between words
    frame(32'hC500_0000, 32'h89AB_CDEF, 32'h0123_4567, 32'hFFFF_FFFF, 2);
    expect_commit("t5", V4, V2);

    // Reset mid-frame discards the partial load
    xfer(32'hC500_0000);
    xfer(32'h1234_5678);
    xfer(32'h9ABC_DEF0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cb",   {31'b0, ConfigBits},   96'd0);
    chk("t6_cbn",  {31'b0, ConfigBits_N}, {31'b0, {N{1'b1}}});
    chk("t6_err",  {95'b0, cfg_err},      96'd0);
    chk("t6_rdy",  {95'b0, cfg_ready},    96'd1);
    chk("t6_done", {95'b0, cfg_done},     96'd0);
    frame(32'hC500_0000, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 0);
    expect_commit("t6", '0, V3);

    // Random traffic; the negedge monitor checks the complement invariant
    for (int c = 0; c < 300; c++) begin
      cfg_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       cfg_data = 32'hC500_0000;
        1:       cfg_data = {8'hC5, 8'h00, 15'h0, 1'($urandom_range(0, 1))};
        2:       cfg_data = {8'($urandom), 24'h0};
        default: cfg_data = $urandom;
      endcase
      tick();
    end
    cfg_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
